spram_frame_buffer_ctrl: RTL and testbench

- Stream-side controller directly upstream and downstream of the 4096x40 single-port RAM.
- Accepts a valid/ready input stream, writes one frame of up to NUM_WORDS words into the RAM, then reads the frame back out as a valid/ready stream in write order.
- Hides the RAM's 1-cycle registered read latency and absorbs output backpressure with a 2-entry output buffer.
- The RAM is single-port, so fill and drain never overlap.

---
 rtl/spram_frame_buffer_ctrl.sv | 123 ++++++++++++
 tb/tb_spram_frame_buffer_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spram_frame_buffer_ctrl.sv
// spram_frame_buffer_ctrl: writes one frame from a valid/ready stream into a single-port RAM, then streams it back out in write order
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last   input frame stream
//   out_valid/out_ready/out_data/out_last  output frame stream (2-entry buffer hides RAM read latency)
//   ram_address/ram_wren/ram_data       RAM request side; ram_out is read data, valid 1 cycle after a read
//   frame_len                           length of the last completed fill (1..NUM_WORDS)
//   busy                                high while the frame is being drained
//   replay                              only with SPRAM_FRAME_REPLAY_EN: re-drain the stored frame
module spram_frame_buffer_ctrl #(
   parameter int AWIDTH    = 12,
   parameter int NUM_WORDS = 4096,
   parameter int DWIDTH    = 40
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_last,
   output logic [AWIDTH-1:0] ram_address,
   output logic              ram_wren,
   output logic [DWIDTH-1:0] ram_data,
   input  logic [DWIDTH-1:0] ram_out,
`ifdef SPRAM_FRAME_REPLAY_EN
   input  logic              replay,
`endif
   output logic [AWIDTH:0]   frame_len,
   output logic              busy
);
   typedef enum logic {FILL, DRAIN} state_t;
   state_t            state_q, state_d;
   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d, len_q, len_d;
   logic [DWIDTH:0]   b0_q, b0_d, b1_q, b1_d;
   logic [1:0]        cnt_q, cnt_d, n;
   logic              fl_q, fl_d, fl_last_q, fl_last_d;
   logic              fill, replay_go, accept, fill_done, pop, issue, drain_done;
   logic [2:0]        occ;
`ifdef SPRAM_FRAME_REPLAY_EN
   assign replay_go = fill & replay & (wr_ptr_q == '0) & (len_q != '0);
`else
   assign replay_go = 1'b0;
`endif
   assign fill        = state_q == FILL;
   assign in_ready    = fill & resetn & ~replay_go;
   assign accept      = in_valid & in_ready;
   assign fill_done   = accept & (in_last | (wr_ptr_q == AWIDTH'(NUM_WORDS - 1)));
   assign out_valid   = cnt_q != 2'd0;
   assign out_data    = b0_q[DWIDTH-1:0];
   assign out_last    = out_valid & b0_q[DWIDTH];
   assign pop         = out_valid & out_ready;
   // occupancy after this cycle's pop plus the read still in flight, so the buffer never overflows
   assign occ         = {1'b0, cnt_q} - {2'b0, pop} + {2'b0, fl_q};
   assign issue       = ~fill & (rd_ptr_q < len_q) & (occ < 3'd2);
   assign drain_done  = ~fill & pop & b0_q[DWIDTH];
   assign n           = cnt_q - {1'b0, pop};
   assign ram_wren    = accept;
   assign ram_data    = in_data;
   assign ram_address = fill ? wr_ptr_q : rd_ptr_q[AWIDTH-1:0];
   assign frame_len   = len_q;
   assign busy        = ~fill;
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      len_d     = len_q;
      fl_d      = issue;
      fl_last_d = fl_last_q;
      b0_d      = pop ? b1_q : b0_q;
      b1_d      = b1_q;
      cnt_d     = n + {1'b0, fl_q};
      if (fill_done) begin
         len_d    = {1'b0, wr_ptr_q} + (AWIDTH+1)'(1);
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         state_d  = DRAIN;
      end else if (accept) begin
         wr_ptr_d = wr_ptr_q + AWIDTH'(1);
      end
      if (replay_go) begin
         rd_ptr_d = '0;
         state_d  = DRAIN;
      end
      if (issue) begin
         rd_ptr_d  = rd_ptr_q + (AWIDTH+1)'(1);
         fl_last_d = rd_ptr_q == len_q - (AWIDTH+1)'(1);
      end
      // read data lands behind whatever survives this cycle's pop
      if (fl_q) begin
         if (n == 2'd0) b0_d = {fl_last_q, ram_out};
         else           b1_d = {fl_last_q, ram_out};
      end
      if (drain_done) state_d = FILL;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= FILL;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         len_q     <= '0;
         b0_q      <= '0;
         b1_q      <= '0;
         cnt_q     <= '0;
         fl_q      <= 1'b0;
         fl_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         len_q     <= len_d;
         b0_q      <= b0_d;
         b1_q      <= b1_d;
         cnt_q     <= cnt_d;
         fl_q      <= fl_d;
         fl_last_q <= fl_last_d;
      end
   end
endmodule

// File: tb/tb_spram_frame_buffer_ctrl.sv
// tb_spram_frame_buffer_ctrl: scoreboard bench for spram_frame_buffer_ctrl with a behavioural RAM
module tb_spram_frame_buffer_ctrl;
   localparam int AW = 12, NW = 4096, DW = 40;
   logic          clk = 0, resetn = 0, in_valid = 0, in_last = 0, out_ready = 0;
   logic [DW-1:0] in_data = '0, ram_out, out_data, ram_data;
   logic [AW-1:0] ram_address;
   logic [AW:0]   frame_len;
   logic          in_ready, out_valid, out_last, ram_wren, busy;
   bit            rnd_ready = 0;
`ifdef SPRAM_FRAME_REPLAY_EN
   logic          replay = 0;
`endif
   int checks = 0, failures = 0;
   logic [DW:0] exp_q[$];
   logic [DW:0] last_frame[$];
   logic [DW-1:0] mem [NW];

   spram_frame_buffer_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW)) dut (
`ifdef SPRAM_FRAME_REPLAY_EN
      .replay(replay),
`endif
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
      .ram_out(ram_out), .frame_len(frame_len), .busy(busy));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_out <= mem[ram_address];
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   initial begin
      logic [DW:0] held, e;
      bit stall = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            stall = 0;
            continue;
         end
         if (stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", {out_last, out_data}, held);
         end
         if (out_valid && out_ready) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_beat", {out_last, out_data}, e);
            end
         end
         stall = out_valid && !out_ready;
         held  = {out_last, out_data};
      end
   end

   initial forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic send_frame(int n, bit use_last, bit rnd, logic [DW-1:0] base);
      logic [DW-1:0] d;
      last_frame.delete();
      for (int i = 0; i < n; i++) begin
         int t = 0;
         d = rnd ? DW'({$urandom(), $urandom()}) : base + DW'(i);
         last_frame.push_back({i == n - 1, d});
         exp_q.push_back({i == n - 1, d});
         in_valid = 1;
         in_data  = d;
         in_last  = use_last && (i == n - 1);
         @(negedge clk);
         while (!in_ready && t < 20000) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) chk("in_ready_wait", in_ready, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      in_last  = 0;
      chk("frame_len", frame_len, n);
      chk("busy_after_fill", busy, 1);
   endtask

   task automatic wait_drain();
      int t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_done", {exp_q.size() != 0, busy}, 0);
      chk("in_ready_after_drain", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_frame_len", frame_len, 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1;
`ifdef SPRAM_FRAME_REPLAY_EN
      replay = 1;
      @(negedge clk);
      chk("replay_empty_in_ready", in_ready, 1);
      @(posedge clk);
      #1 replay = 0;
      chk("replay_empty_busy", busy, 0);
`endif
      // reset in the middle of a stalled drain
      out_ready = 0;
      send_frame(3, 1, 1, '0);
      repeat (4) @(posedge clk);
      #3 resetn = 0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_frame_len", frame_len, 0);
      chk("mid_rst_out_data", {out_last, out_data}, 0);
      exp_q.delete();
      @(posedge clk);
      #1 resetn = 1;
      out_ready = 1;
      send_frame(3, 1, 0, 40'hA);
      wait_drain();
      // single-word frame and first-beat latency
      send_frame(1, 1, 0, 40'hFF_0000_0001);
      begin
         int k = 1;
         @(negedge clk);
         while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
         end
         chk("first_valid_latency", k, 3);
      end
      wait_drain();
      // throughput with no backpressure
      send_frame(16, 1, 1, '0);
      begin
         int t = 0, c = 0;
         @(negedge clk);
         while (!out_valid && t < 10) begin
            @(negedge clk);
            t++;
         end
         while (out_valid && c < 100) begin
            c++;
            @(negedge clk);
         end
         chk("no_bubbles", c, 16);
      end
      wait_drain();
      // random backpressure
      rnd_ready = 1;
      send_frame(8, 1, 1, '0);
      wait_drain();
      for (int f = 0; f < 4; f++) begin
         send_frame(int'($urandom_range(1, 20)), 1, 1, '0);
         wait_drain();
      end
      rnd_ready = 0;
      @(posedge clk);
      #1 out_ready = 1;
      // full-capacity frame ends on its own
      send_frame(NW, 0, 0, '0);
      wait_drain();
`ifdef SPRAM_FRAME_REPLAY_EN
      send_frame(5, 1, 1, '0);
      wait_drain();
      foreach (last_frame[i]) exp_q.push_back(last_frame[i]);
      replay = 1;
      @(posedge clk);
      #1 replay = 0;
      chk("replay_busy", busy, 1);
      wait_drain();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule
